// File: rtl/page_stepper_pkg.sv
// Shared command and state encodings for the page stepper.
package page_stepper_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_LOAD   = 2'b01,
        OP_FINE   = 2'b10,
        OP_COARSE = 2'b11
    } op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/page_step_calc.sv
// Combinational step core: +1 or bump to next 2^LSB boundary, falling back to reload_val on overflow.
// Zero latency, no flow control.
module page_step_calc #(
    parameter int WIDTH = 16,
    parameter int LSB   = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] reload_val,
    input  logic             coarse,
    output logic [WIDTH-1:0] next,
    output logic             wrap
);

    localparam int HW = WIDTH - LSB;

    logic [HW-1:0] hi;
    logic [HW-1:0] hi_inc;

    assign hi     = count[WIDTH-1:LSB];
    assign hi_inc = hi + HW'(1);

    always_comb begin
        next = count + WIDTH'(1);
        wrap = 1'b0;
        if (coarse) begin
            if (&hi) begin
                next = reload_val;
                wrap = 1'b1;
            end else begin
                next = {hi_inc, {LSB{1'b0}}};
            end
        end else if (&count) begin
            next = reload_val;
            wrap = 1'b1;
        end
    end

endmodule

// File: rtl/page_stepper.sv
// Registered count with load / fine / coarse step commands and 1..2^REP_W step bursts; first step lands on the
// accept edge, done follows the last step; cmd_ready is low for the whole burst and nothing is buffered.
module page_stepper
    import page_stepper_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               LSB       = 8,
    parameter int               REP_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [REP_W-1:0] cmd_rep,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] reload_val,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] count,
    output logic             wrap_pulse,
    output logic             wrap_sticky,
    output logic             done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [REP_W-1:0]   rem_q, rem_d;
    logic               coarse_q, coarse_d;
    logic               wrap_pulse_q, wrap_pulse_d;
    logic               wrap_sticky_q, wrap_sticky_d;
    logic               done_q, done_d;

    logic               step_en;
    logic               step_coarse;
    logic [WIDTH-1:0]   step_next;
    logic               step_wrap;

    // In IDLE the step kind comes straight from the command; in RUN from the latched burst kind.
    assign step_coarse = (state_q == S_IDLE) ? (cmd_op == OP_COARSE) : coarse_q;

    page_step_calc #(
        .WIDTH (WIDTH),
        .LSB   (LSB)
    ) u_calc (
        .count      (count_q),
        .reload_val (reload_val),
        .coarse     (step_coarse),
        .next       (step_next),
        .wrap       (step_wrap)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rem_d    = rem_q;
        coarse_d = coarse_q;
        done_d   = 1'b0;
        step_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_NOP: done_d = 1'b1;
                        OP_LOAD: begin
                            count_d = load_val;
                            done_d  = 1'b1;
                        end
                        default: begin
                            step_en  = 1'b1;
                            count_d  = step_next;
                            coarse_d = step_coarse;
                            rem_d    = cmd_rep;
                            if (step_wrap || cmd_rep == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = S_RUN;
                            end
                        end
                    endcase
                end
            end
            default: begin
                step_en = 1'b1;
                count_d = step_next;
                rem_d   = rem_q - REP_W'(1);
                // A wrap abandons whatever is left of the burst.
                if (step_wrap || rem_q == REP_W'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
        wrap_pulse_d  = step_en && step_wrap;
        wrap_sticky_d = wrap_pulse_d || (wrap_sticky_q && !clr_sticky);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            count_q       <= RESET_VAL;
            rem_q         <= '0;
            coarse_q      <= 1'b0;
            wrap_pulse_q  <= 1'b0;
            wrap_sticky_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            rem_q         <= rem_d;
            coarse_q      <= coarse_d;
            wrap_pulse_q  <= wrap_pulse_d;
            wrap_sticky_q <= wrap_sticky_d;
            done_q        <= done_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign count       = count_q;
    assign wrap_pulse  = wrap_pulse_q;
    assign wrap_sticky = wrap_sticky_q;
    assign done        = done_q;

endmodule

// File: doc/page_stepper.md
Name: page_stepper

Overview:
- Registered, parametrised address/page counter for the lab datapath. It is the sequential successor to the combinational 16-bit "bump to next 256 boundary, else fall back" stepper.
- Holds a WIDTH-bit count and applies one command type per accepted command: load, fine step (+1) or coarse step (next 2^LSB boundary).
- Step commands can be bursts of 1..2^REP_W steps, executed one per cycle.
- On overflow the count reloads from an external fallback value and a wrap flag is raised.

Parameters:
- WIDTH, 16, count width in bits.
- LSB, 8, coarse granule exponent; coarse step clears bits [LSB-1:0]; legal range 1..WIDTH-1.
- REP_W, 4, burst repeat field width; a burst is rep+1 steps.
- RESET_VAL, 0, count value after reset.

Ports:
- clk, in, 1, system clock (rising edge).
- rst_n, in, 1, asynchronous active-low reset.
- cmd_valid, in, 1, command request.
- cmd_ready, out, 1, high when in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_op, in, 2, 00 NOP, 01 LOAD, 10 FINE, 11 COARSE.
- cmd_rep, in, REP_W, burst length minus 1 (ignored for NOP and LOAD).
- load_val, in, WIDTH, value for LOAD.
- reload_val, in, WIDTH, fallback value loaded on wrap; sampled on the cycle the wrap occurs.
- clr_sticky, in, 1, clears wrap_sticky.
- count, out, WIDTH, current registered count.
- wrap_pulse, out, 1, one-cycle pulse on the cycle after a wrap update.
- wrap_sticky, out, 1, set by any wrap, held until clr_sticky.
- done, out, 1, one-cycle pulse when an accepted command finishes.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, count=RESET_VAL, wrap_pulse=0, wrap_sticky=0, done=0, cmd_ready=1 once released. Reset mid-burst aborts the burst immediately.
- FSM states:
  - IDLE: cmd_ready=1.
  - RUN: cmd_ready=0, remaining-step counter rem.
- Accept in IDLE:
  - NOP: done=1 next cycle, count unchanged.
  - LOAD: count<=load_val; done=1 next cycle; no wrap.
  - FINE or COARSE: the first step is applied on the accept edge. If cmd_rep==0, done=1 next cycle and the FSM stays in IDLE. Otherwise the FSM enters RUN with rem=cmd_rep.
- RUN:
  - One step per cycle, rem decrements.
  - On the step that makes rem reach 0: go to IDLE, done=1 next cycle.
- FINE step:
  - If count==all ones: count<=reload_val, wrap.
  - Else count<=count+1.
- COARSE step:
  - Let hi=count[WIDTH-1:LSB].
  - If hi==all ones: count<=reload_val, wrap.
  - Else count<={hi+1, LSB'b0}.
  - Equivalent form: set the lowest zero bit at or above LSB and clear all bits below it.
- Wrap:
  - wrap_pulse=1 for the next cycle; wrap_sticky<=1.
  - A wrap terminates any burst: go to IDLE, done=1 with the wrap_pulse, remaining steps discarded.
- Sticky flag: if clr_sticky and a wrap occur in the same cycle, set wins (wrap_sticky=1).
- Output timing: count, wrap_pulse and done are all registered. Latency from accept to first count update is 1 edge. A burst of N steps raises done N cycles after accept.
- Commands presented while cmd_ready=0 are not accepted. The requester must hold cmd_valid; no buffering.
- reload_val is not range-checked. A reload to a value whose hi is all ones is legal; the next coarse step wraps again.

Decomposition:
- Package page_stepper_pkg holds:
  - typedef enum logic [1:0] op_t {OP_NOP, OP_LOAD, OP_FINE, OP_COARSE};
  - typedef enum logic state_t {S_IDLE, S_RUN}.
- Sub-module page_step_calc (combinational, parametrised WIDTH/LSB): inputs count, reload_val, coarse; outputs next and wrap. It is the generalised step/fallback core.
- The top module holds the FSM, the rem counter and the flags.

Test Plan:
- Reset: rst_n low mid-burst (COARSE, rep=7, after 3 steps) -> count=0x0000, cmd_ready=1, wrap_sticky=0 asynchronously; no done pulse.
- LOAD 0x12FF then COARSE rep=0 -> count=0x1300, done one cycle after accept, wrap_pulse=0. A further COARSE -> 0x1400.
- FINE burst: LOAD 0xFFFD, reload_val=0x0040, FINE rep=5 -> count steps 0xFFFE, 0xFFFF, then 0x0040. wrap_pulse=1 and done=1 on the same cycle, burst terminated after 3 steps, wrap_sticky=1.
- COARSE overflow: LOAD 0xFF12, reload_val=0xABCD, COARSE rep=0 -> count=0xABCD, wrap_pulse=1.
- Handshake: issue a second command while in RUN (cmd_valid held) -> not accepted until the cycle after done. Then accepted with cmd_ready=1, and count continues correctly.
- Sticky: clr_sticky asserted on the same cycle as a wrap -> wrap_sticky stays 1. clr_sticky alone next cycle -> 0.
- Parameter sweep: WIDTH=8, LSB=3. LOAD 0x2F, COARSE -> 0x30. LOAD 0xF8, COARSE -> reload_val.
